// File: rtl/mux_4to1.sv
// Registered 4:1 multiplexer: gate-level per-bit select datapath feeding an
// enable-gated output register with an asynchronous, active-high reset.
module mux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             S1,
    input  logic             S2,
    output logic [WIDTH-1:0] Y_comb,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       sel_q
);

    // Select literals are shared across bits; X/Z on S1/S2 flows through
    // these gates with no special-casing.
    logic s1_n;
    logic s2_n;

    assign s1_n = ~S1;
    assign s2_n = ~S2;

    logic [WIDTH-1:0] term0;
    logic [WIDTH-1:0] term1;
    logic [WIDTH-1:0] term2;
    logic [WIDTH-1:0] term3;

    // One 3-input AND per data input and one 4-input OR, replicated per bit.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign term0[b]  = I0[b] & s1_n & s2_n;
        assign term1[b]  = I1[b] & s1_n & S2;
        assign term2[b]  = I2[b] & S1   & s2_n;
        assign term3[b]  = I3[b] & S1   & S2;
        assign Y_comb[b] = term0[b] | term1[b] | term2[b] | term3[b];
    end

    // en is a plain load strobe: Y and sel_q hold indefinitely while it is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y     <= '0;
            sel_q <= 2'b00;
        end else if (en) begin
            Y     <= Y_comb;
            sel_q <= {S1, S2};
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1 (WIDTH = 8): directed scenarios plus random stimulus,
// with registered outputs checked from an expected-value queue.
module tb_mux_4to1;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] i0, i1, i2, i3;
    logic         s1, s2;
    logic [W-1:0] y_comb;
    logic [W-1:0] y;
    logic [1:0]   sel_q;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected {sel_q, Y} after each clock edge.
    logic [W+1:0] exp_q[$];

    // Reference register state.
    logic [W-1:0] model_y;
    logic [1:0]   model_sel;

    mux_4to1 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .I0     (i0),
        .I1     (i1),
        .I2     (i2),
        .I3     (i3),
        .S1     (s1),
        .S2     (s2),
        .Y_comb (y_comb),
        .Y      (y),
        .sel_q  (sel_q)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, b, c, d,
                                              input logic [1:0] sel);
        logic [W-1:0] data [4];
        data[0] = a;
        data[1] = b;
        data[2] = c;
        data[3] = d;
        return data[sel];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [W-1:0] a, b, c, d, input logic [1:0] sel,
                        input logic e);
        i0 = a; i1 = b; i2 = c; i3 = d;
        {s1, s2} = sel;
        en = e;
        #1;
        chk("y_comb", 32'(y_comb), 32'(ref_mux(a, b, c, d, sel)));
        @(posedge clk);
        #1;
        if (rst) begin
            model_y   = '0;
            model_sel = 2'b00;
        end else if (e) begin
            model_y   = ref_mux(a, b, c, d, sel);
            model_sel = sel;
        end
        exp_q.push_back({model_sel, model_y});
    endtask

    // Pulse rst between edges; registers must clear at once, Y_comb untouched.
    task automatic async_pulse(input logic hold_edges);
        logic [W-1:0] yc_before;
        @(negedge clk);
        #1;
        yc_before = y_comb;
        rst = 1'b1;
        #1;
        model_y   = '0;
        model_sel = 2'b00;
        chk("rst_y_async", 32'(y), 32'(0));
        chk("rst_sel_async", 32'(sel_q), 32'(0));
        chk("rst_ycomb_kept", 32'(y_comb), 32'(yc_before));
        if (!hold_edges) rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W+1:0] e;
            e = exp_q.pop_front();
            chk("y_reg", 32'(y), 32'(e[W-1:0]));
            chk("sel_q", 32'(sel_q), 32'(e[W+1:W]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0; s1 = 1'b0; s2 = 1'b0;
        model_y = '0; model_sel = 2'b00;
        #1;
        chk("por_y", 32'(y), 32'(0));
        chk("por_sel", 32'(sel_q), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Load a nonzero value, then assert reset asynchronously with all inputs high.
        step('1, '1, '1, '1, 2'b11, 1'b1);
        async_pulse(1'b1);
        step('1, '1, '1, '1, 2'b10, 1'b1);
        step('1, '1, '1, '1, 2'b01, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Select sweep, with a mid-stream reset pulse after sel = 10 loads.
        for (int s = 0; s < 4; s++) begin
            step(8'd1, 8'd0, 8'd1, 8'd0, 2'(s), 1'b1);
            if (s == 2) begin
                async_pulse(1'b0);
                step(8'd1, 8'd0, 8'd1, 8'd0, 2'(s), 1'b1);
            end
        end

        // Hold: load 1 from sel 00, then switch to sel 01 with en low.
        step(8'd1, 8'd0, 8'd1, 8'd0, 2'b00, 1'b1);
        repeat (4) step(8'd1, 8'd0, 8'd1, 8'd0, 2'b01, 1'b0);
        step(8'd1, 8'd0, 8'd1, 8'd0, 2'b01, 1'b1);

        // Full-width patterns.
        for (int s = 0; s < 4; s++)
            step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'(s), 1'b1);

        // Exhaustive bit-0 sweep; upper bits random.
        for (int c = 0; c < 64; c++) begin
            logic [5:0] cv;
            cv = 6'(c);
            step({7'($urandom), cv[0]}, {7'($urandom), cv[1]},
                 {7'($urandom), cv[2]}, {7'($urandom), cv[3]},
                 cv[5:4], 1'($urandom_range(0, 1)));
        end

        // Random traffic with random enable.
        for (int k = 0; k < 200; k++)
            step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

        // Drain the scoreboard within a bounded number of cycles.
        repeat (4) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
